// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single RAM port
// Serialises read/write transactions with a watchdog that forces an error completion.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] r0_address,
  input  logic [31:0]   r0_wdata,
  input  logic          r0_readReq,
  input  logic          r0_writeReq,
  output logic [31:0]   r0_rdata,
  output logic          r0_readAck,
  output logic          r0_writeAck,
  output logic          r0_error,
  input  logic [AW-1:0] r1_address,
  input  logic [31:0]   r1_wdata,
  input  logic          r1_readReq,
  input  logic          r1_writeReq,
  output logic [31:0]   r1_rdata,
  output logic          r1_readAck,
  output logic          r1_writeAck,
  output logic          r1_error,
  output logic [AW-1:0] ramAddress,
  output logic [31:0]   ramOut,
  output logic          readReq,
  output logic          writeReq,
  input  logic [31:0]   ramValue,
  input  logic          readAck,
  input  logic          writeAck,
  output logic [1:0]    grant,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  state_t        r_state, w_next;
  logic          r_rr, r_owner, r_is_read, r_err;
  logic [1:0]    r_mask;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_rdata;
  logic [15:0]   r_cnt;

  logic w_pend0, w_pend1, w_any, w_win, w_ack_match, w_timeout;

  assign w_pend0     = (r0_readReq | r0_writeReq) & ~r_mask[0];
  assign w_pend1     = (r1_readReq | r1_writeReq) & ~r_mask[1];
  assign w_any       = w_pend0 | w_pend1;
  assign w_win       = (w_pend0 & w_pend1) ? r_rr : w_pend1;
  assign w_ack_match = r_is_read ? readAck : writeAck;
  assign w_timeout   = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_ack_match || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= 1'b0; r_owner <= 1'b0; r_is_read <= 1'b0; r_err <= 1'b0;
      r_mask <= 2'b00; r_addr <= '0; r_wdata <= '0; r_rdata <= '0; r_cnt <= '0;
      r0_rdata <= '0; r0_readAck <= 1'b0; r0_writeAck <= 1'b0; r0_error <= 1'b0;
      r1_rdata <= '0; r1_readAck <= 1'b0; r1_writeAck <= 1'b0; r1_error <= 1'b0;
      ramAddress <= '0; ramOut <= '0; readReq <= 1'b0; writeReq <= 1'b0;
      grant <= 2'b00; busy <= 1'b0;
    end else begin
      // Pulses and the served-requester mask live for one cycle only.
      readReq <= 1'b0; writeReq <= 1'b0; r_mask <= 2'b00;
      r0_readAck <= 1'b0; r0_writeAck <= 1'b0; r0_error <= 1'b0; r0_rdata <= '0;
      r1_readAck <= 1'b0; r1_writeAck <= 1'b0; r1_error <= 1'b0; r1_rdata <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner   <= w_win;
          r_addr    <= w_win ? r1_address : r0_address;
          r_wdata   <= w_win ? r1_wdata : r0_wdata;
          r_is_read <= w_win ? r1_readReq : r0_readReq;
          grant     <= w_win ? 2'b10 : 2'b01;
          busy      <= 1'b1;
        end
        S_ISSUE: begin
          ramAddress <= r_addr;
          ramOut     <= r_wdata;
          readReq    <= r_is_read;
          writeReq   <= ~r_is_read;
          r_cnt      <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_ack_match) begin
            r_rdata <= r_is_read ? ramValue : 32'd0;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
          end
        end
        S_RESP: begin
          if (r_owner) begin
            r1_readAck <= r_is_read; r1_writeAck <= ~r_is_read;
            r1_rdata   <= r_rdata;   r1_error    <= r_err;
          end else begin
            r0_readAck <= r_is_read; r0_writeAck <= ~r_is_read;
            r0_rdata   <= r_rdata;   r0_error    <= r_err;
          end
          r_rr   <= ~r_owner;
          r_mask <= r_owner ? 2'b10 : 2'b01;
          grant  <= 2'b00;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Requester drivers push expectations; a negedge monitor pops and compares on every ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  rq_rd = 2'b00, rq_wr = 2'b00;
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wd [2];
  logic [31:0] r0_rdata, r1_rdata, ramAddress, ramOut;
  logic        r0_readAck, r0_writeAck, r0_error, r1_readAck, r1_writeAck, r1_error;
  logic        readReq, writeReq, busy;
  logic [1:0]  grant;
  logic [31:0] ramValue = 32'd0;
  logic        readAck = 1'b0, writeAck = 1'b0;

  mem_arbiter #(.TIMEOUT(8), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .r0_address(rq_addr[0]), .r0_wdata(rq_wd[0]), .r0_readReq(rq_rd[0]), .r0_writeReq(rq_wr[0]),
    .r0_rdata(r0_rdata), .r0_readAck(r0_readAck), .r0_writeAck(r0_writeAck), .r0_error(r0_error),
    .r1_address(rq_addr[1]), .r1_wdata(rq_wd[1]), .r1_readReq(rq_rd[1]), .r1_writeReq(rq_wr[1]),
    .r1_rdata(r1_rdata), .r1_readAck(r1_readAck), .r1_writeAck(r1_writeAck), .r1_error(r1_error),
    .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
    .ramValue(ramValue), .readAck(readAck), .writeAck(writeAck), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    int          lat;
  } exp_t;

  exp_t        sbq0[$], sbq1[$];
  logic [7:0]  mem [1024];
  logic [7:0]  ref_mem [1024];
  logic [1:0]  grant_log[$];
  int          grant_time[$];
  int          total = 0, bad = 0, cyc = 0, rd_pulses = 0, last_issue = 0;
  bit          mem_mute = 1'b0, prev_req = 1'b0;
  logic [1:0]  prev_grant = 2'b00;

  wire [1:0]  ack_rd  = {r1_readAck, r0_readAck};
  wire [1:0]  ack_wr  = {r1_writeAck, r0_writeAck};
  wire [1:0]  ack_any = ack_rd | ack_wr;
  wire [1:0]  ack_err = {r1_error, r0_error};
  wire [31:0] ack_dat [2] = '{r0_rdata, r1_rdata};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [9:0] b = a[9:0];
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    logic [9:0] b = a[9:0];
    for (int i = 0; i < 4; i++) ref_mem[b + 10'(i)] = d[8*i +: 8];
  endtask

  always @(posedge clk) cyc++;

  // Memory: samples a request pulse and answers one cycle later (L=1), unless muted.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    forever begin
      @(negedge clk);
      if (reset && !mem_mute && (readReq || writeReq)) begin
        logic [9:0]  a;
        logic [31:0] d;
        bit          rd;
        a = ramAddress[9:0]; d = ramOut; rd = readReq;
        @(posedge clk); #1;
        if (rd) begin
          ramValue = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
          readAck = 1'b1;
        end else begin
          for (int i = 0; i < 4; i++) mem[a + 10'(i)] = d[8*i +: 8];
          writeAck = 1'b1;
        end
        @(posedge clk); #1;
        readAck = 1'b0; writeAck = 1'b0; ramValue = $urandom;
      end
    end
  end

  // Monitor: memory-side issue checks, grant logging, and scoreboard pops on acks.
  always @(negedge clk) begin
    if (readReq || writeReq) begin
      int o;
      o = grant[1] ? 1 : 0;
      chk("grant_onehot", 64'(grant == 2'b01 || grant == 2'b10), 64'd1);
      chk("ram_addr", 64'(ramAddress), 64'(rq_addr[o]));
      if (writeReq) chk("ram_wdata", 64'(ramOut), 64'(rq_wd[o]));
      chk("req_single_pulse", 64'(prev_req), 64'd0);
      if (readReq) rd_pulses++;
      last_issue = cyc;
    end
    prev_req = readReq | writeReq;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      grant_log.push_back(grant);
      grant_time.push_back(cyc);
    end
    prev_grant = grant;
    if (ack_any != 2'b00) chk("one_ack_at_a_time", 64'(ack_any == 2'b11), 64'd0);
    for (int r = 0; r < 2; r++) begin
      if (ack_any[r]) begin
        exp_t e;
        if ((r == 0 ? sbq0.size() : sbq1.size()) == 0) begin
          chk($sformatf("unexpected_ack_r%0d", r), 64'd1, 64'd0);
        end else begin
          e = (r == 0) ? sbq0.pop_front() : sbq1.pop_front();
          chk($sformatf("ack_type_r%0d", r), 64'({ack_rd[r], ack_wr[r]}), e.rd ? 64'd2 : 64'd1);
          chk($sformatf("ack_error_r%0d", r), 64'(ack_err[r]), 64'(e.err));
          if (e.rd) chk($sformatf("rdata_r%0d", r), 64'(ack_dat[r]), 64'(e.data));
          chk($sformatf("latency_r%0d", r), 64'(cyc - last_issue), 64'(e.lat));
        end
      end
    end
  end

  task automatic txn(input int r, input bit rd, input logic [31:0] a, input logic [31:0] d,
                     input int hold, input bit mute);
    exp_t e;
    int   n;
    @(negedge clk);
    rq_addr[r] = a; rq_wd[r] = d; rq_rd[r] = rd; rq_wr[r] = !rd;
    e.rd = rd; e.err = mute; e.lat = mute ? 9 : 3; e.data = 32'd0;
    if (!mute) begin
      if (rd) e.data = ref_rd(a);
      else ref_wr(a, d);
    end
    if (r == 0) sbq0.push_back(e); else sbq1.push_back(e);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack_any[r] && n < 200);
    if (!ack_any[r]) chk($sformatf("ack_wait_r%0d", r), 64'd0, 64'd1);
    repeat (hold) begin @(posedge clk); #1; end
    rq_rd[r] = 1'b0; rq_wr[r] = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int p, n;
    rq_addr[0] = 32'h10; rq_addr[1] = 32'h200; rq_wd[0] = 32'd0; rq_wd[1] = 32'd0;
    rq_rd[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 64'(|{r0_rdata, r0_readAck, r0_writeAck, r0_error,
                                   r1_rdata, r1_readAck, r1_writeAck, r1_error,
                                   ramAddress, ramOut, readReq, writeReq, grant, busy}), 64'd0);
    reset = 1'b1;
    txn(0, 1'b1, 32'h10, 32'd0, 0, 1'b0);
    chk("first_read_pulses", 64'(rd_pulses), 64'd1);

    txn(0, 1'b0, 32'h20, 32'hCAFEF00D, 0, 1'b0);
    txn(0, 1'b1, 32'h20, 32'd0, 0, 1'b0);
    chk("write_read_back", 64'(ref_rd(32'h20)), 64'hCAFEF00D);

    do_reset(2);
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) txn(0, 1'b1, 32'(i * 4), 32'd0, 0, 1'b0);
      for (int i = 0; i < 4; i++) txn(1, 1'b1, 32'(32'h200 + i * 4), 32'd0, 0, 1'b0);
    join
    chk("contention_grants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk($sformatf("alternation_%0d", i), 64'(grant_log[i]), (i % 2 == 0) ? 64'd1 : 64'd2);

    p = rd_pulses;
    txn(0, 1'b1, 32'h40, 32'd0, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("mask_single_pulse", 64'(rd_pulses - p), 64'd1);

    grant_time.delete();
    for (int i = 0; i < 3; i++) txn(0, 1'b1, 32'(32'h80 + i * 4), 32'd0, 0, 1'b0);
    chk("b2b_grants", 64'(grant_time.size()), 64'd3);
    for (int i = 1; i < grant_time.size(); i++)
      chk($sformatf("b2b_period_%0d", i), 64'(grant_time[i] - grant_time[i-1]), 64'd6);

    mem_mute = 1'b1;
    txn(1, 1'b1, 32'h240, 32'd0, 0, 1'b1);
    mem_mute = 1'b0;
    txn(0, 1'b1, 32'h44, 32'd0, 0, 1'b0);

    mem_mute = 1'b1;
    @(negedge clk);
    rq_addr[1] = 32'h250; rq_rd[1] = 1'b1;
    n = 0;
    while (!readReq && n < 50) begin @(negedge clk); n++; end
    chk("reset_wait_issue_seen", 64'(readReq), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_grant", 64'(grant), 64'd0);
    rq_rd[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_mute = 1'b0;
    repeat (12) @(negedge clk);
    txn(1, 1'b1, 32'h250, 32'd0, 0, 1'b0);

    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        txn(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127) << 2), $urandom,
            int'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        txn(1, 1'($urandom_range(0, 1)), 32'(32'h200 + ($urandom_range(0, 127) << 2)), $urandom,
            int'($urandom_range(0, 1)), 1'b0);
      end
    join
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq0.size() + sbq1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter sharing the single 32-bit byte-addressed RAM port between the ALU (requester 0) and a second master such as a DMA or loader (requester 1). It uses the same readReq/writeReq/readAck/writeAck handshake on both sides. It sits between the masters and the memory model/controller. It serialises transactions with round-robin fairness and has a watchdog that returns an error if memory never acknowledges.

Parameters:
TIMEOUT, 255, max cycles in WAIT before forced error completion (1..65535)
AW, 32, address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 = reset
r0_address  in  AW  requester 0 byte address
r0_wdata  in  32  requester 0 write data
r0_readReq  in  1  requester 0 read request, held until ack
r0_writeReq  in  1  requester 0 write request, held until ack
r0_rdata  out  32  read data to requester 0, valid with r0_readAck
r0_readAck  out  1  one-cycle read completion pulse
r0_writeAck  out  1  one-cycle write completion pulse
r0_error  out  1  high with ack when completion was a timeout
r1_*  same set of 8 ports for requester 1
ramAddress  out  AW  address to memory
ramOut  out  32  write data to memory
readReq  out  1  one-cycle read request pulse to memory
writeReq  out  1  one-cycle write request pulse to memory
ramValue  in  32  read data from memory
readAck  in  1  memory read completion
writeAck  in  1  memory write completion
grant  out  2  one-hot owner of current transaction; 00 when idle
busy  out  1  high in any state but IDLE

Behaviour:
- All outputs are registered. While reset=0, every output is 0, the state is IDLE, the rr pointer is 0 (requester 0 preferred), and the mask is clear. Reset mid-transaction abandons it; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: a requester is pending if readReq|writeReq is high and it is not masked.
  - If both are pending, the winner is the requester selected by rr.
  - Latch the winner's address, wdata and type (read if its readReq=1, else write; readReq wins if both are high).
  - Set grant, then go to ISSUE.
- ISSUE: drive ramAddress/ramOut from the latch. Assert readReq or writeReq for exactly one cycle, clear the watchdog counter, then go to WAIT.
- WAIT: ramAddress/ramOut are held stable and the counter increments each cycle.
  - An ack matching the latched type captures ramValue (reads only) and goes to RESP with error=0.
  - A non-matching ack is ignored.
  - When the counter reaches TIMEOUT-1 with no ack, go to RESP with error=1 and rdata=0.
- RESP: pulse the owner's readAck or writeAck for one cycle, with rdata and error valid in that cycle.
  - Set rr to the other requester and mask the served requester for the next cycle only.
  - Clear grant and go to IDLE.
- Mask rule: a requester must drop its req by the edge after seeing its ack. The mask prevents a duplicate grant in that cycle.
- Latency: from the first edge sampling a request in IDLE, the upstream ack is high after edge 3+L. L is the memory delay, counted from the req pulse sample to ack high (L=1 for the single-cycle bench memory, giving ack 4 cycles after sampling).
- Only one transaction is outstanding at a time. Requests arriving while busy wait without loss and are served strictly alternately under contention.
- A late memory ack after a timeout is ignored in IDLE/ISSUE/RESP. Memory latency must stay below TIMEOUT.
- Back-to-back single requester: req, ack, drop, re-assert gives a grant every 6 cycles with L=1.

Test Plan:
- Reset held low 3 cycles while r0_readReq=1 -> all outputs 0; after release, read of 0x10 granted, readReq pulses once with ramAddress=0x10, r0_readAck=1 with r0_rdata=the 4 bytes at 0x10..0x13 little-endian.
- r0 write 0xCAFEF00D to 0x20, then r0 read 0x20 -> writeAck pulse, then readAck with rdata=0xCAFEF00D; r1 acks stay 0.
- r0 and r1 both request reads on the same cycle from reset -> r0 is served first, then r1; 4 reads each held continuously -> grant order 01,10,01,10,...; no duplicate ack.
- Requester holds readReq one extra cycle after ack (protocol check) -> mask prevents a second memory readReq pulse; exactly 1 pulse on readReq.
- Memory model never acks, TIMEOUT=8 -> r1_readAck=1, r1_error=1, r1_rdata=0 exactly 9 cycles after ISSUE; arbiter returns to IDLE and serves the next r0 request normally.
- Reset asserted during WAIT -> busy=0, grant=00 immediately (asynchronously); no ack pulses; a fresh request after release completes normally.
